// File: rtl/vip_pkg.sv
// Shared constants and helpers for the VIP 5x5 window pipeline.
package vip_pkg;

    localparam int VIP_DATA_W = 8;
    localparam int WIN        = 5;
    localparam int HALF       = 2;

    // Bit offset of window element (r,c) inside the flattened matrix bus.
    function automatic int mat_off(input int r, input int c, input int data_w);
        return (r * WIN + c) * data_w;
    endfunction

endpackage

// File: rtl/vip_pos_counter.sv
// Row/column position tracking for the 5x5 window, from href/vsync edges.
module vip_pos_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             href,
    input  logic             clken,
    output logic [CNT_W-1:0] row_pos,
    output logic [CNT_W-1:0] col_pos
);

    logic             vsync_q;
    logic             href_q;
    logic [CNT_W-1:0] row_cnt;
    logic [CNT_W-1:0] col_cnt;
    logic             vsync_rise;
    logic             href_fall;

    assign vsync_rise = vsync & ~vsync_q;
    assign href_fall  = href_q & ~href;

    // Position of the pixel presented this cycle: edge clears take effect immediately.
    assign row_pos = vsync_rise ? '0 : row_cnt;
    assign col_pos = href_fall  ? '0 : col_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
            if (clken && col_pos != '1) begin
                col_cnt <= col_pos + 1'b1;
            end else begin
                col_cnt <= col_pos;
            end
            // Vsync clear wins over an href fall in the same cycle.
            if (vsync_rise) begin
                row_cnt <= '0;
            end else if (href_fall && row_cnt != '1) begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vip_matrix_window_5x5.sv
// Registered 5x5 pixel window with frame-edge padding and sync delay.
// Build option: VIP_MATRIX_BORDER_REPLICATE_EN replicates edge pixels instead of zero padding.
module vip_matrix_window_5x5
    import vip_pkg::*;
#(
    parameter int DATA_W = VIP_DATA_W,
    parameter int CNT_W  = 11
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      per_frame_vsync,
    input  logic                      per_frame_href,
    input  logic                      per_frame_clken,
    input  logic [DATA_W-1:0]         in_row0,
    input  logic [DATA_W-1:0]         in_row1,
    input  logic [DATA_W-1:0]         in_row2,
    input  logic [DATA_W-1:0]         in_row3,
    input  logic [DATA_W-1:0]         in_row4,
    output logic                      matrix_frame_vsync,
    output logic                      matrix_frame_href,
    output logic                      matrix_frame_clken,
    output logic [WIN*WIN*DATA_W-1:0] matrix_p,
    output logic                      matrix_border
);

    localparam int EDGE = 2 * HALF;

    logic [CNT_W-1:0]                    row_pos;
    logic [CNT_W-1:0]                    col_pos;
    logic [WIN-1:0][WIN-1:0][DATA_W-1:0] win_q;
    logic [WIN-1:0][WIN-1:0][DATA_W-1:0] win_d;
    logic [WIN-1:0][DATA_W-1:0]          taps;
    logic [2:0]                          row_lo;
    logic [2:0]                          col_lo;
    logic [WIN*WIN*DATA_W-1:0]           pad_p;
    logic                                border_d;

    vip_pos_counter #(.CNT_W(CNT_W)) u_pos (
        .clock   (clock),
        .rst_n   (rst_n),
        .vsync   (per_frame_vsync),
        .href    (per_frame_href),
        .clken   (per_frame_clken),
        .row_pos (row_pos),
        .col_pos (col_pos)
    );

    // Row 4 is the newest line, so in_row0 feeds the bottom of the window.
    assign taps = {in_row0, in_row1, in_row2, in_row3, in_row4};

    // First in-frame row/column of the window for the pixel being shifted in.
    assign row_lo   = (row_pos < CNT_W'(EDGE)) ? 3'(CNT_W'(EDGE) - row_pos) : 3'd0;
    assign col_lo   = (col_pos < CNT_W'(EDGE)) ? 3'(CNT_W'(EDGE) - col_pos) : 3'd0;
    assign border_d = (row_pos < CNT_W'(EDGE)) || (col_pos < CNT_W'(EDGE));

    always_comb begin
        // NOTE: full default assignment first keeps this block free of inferred latches.
        win_d = win_q;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][WIN-1] = taps[r];
        end
    end

    always_comb begin
        pad_p = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
`ifdef VIP_MATRIX_BORDER_REPLICATE_EN
                pad_p[mat_off(r, c, DATA_W) +: DATA_W] =
                    win_d[(3'(r) < row_lo) ? row_lo : 3'(r)][(3'(c) < col_lo) ? col_lo : 3'(c)];
`else
                if (3'(r) >= row_lo && 3'(c) >= col_lo) begin
                    pad_p[mat_off(r, c, DATA_W) +: DATA_W] = win_d[r][c];
                end
`endif
            end
        end
    end

    // NOTE: window storage is reset too, so a mid-frame reset never exposes stale pixels.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            win_q              <= '0;
            matrix_p           <= '0;
            matrix_border      <= 1'b0;
            matrix_frame_vsync <= 1'b0;
            matrix_frame_href  <= 1'b0;
            matrix_frame_clken <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            matrix_frame_vsync <= per_frame_vsync;
            matrix_frame_href  <= per_frame_href;
            matrix_frame_clken <= per_frame_clken;
            if (per_frame_clken) begin
                win_q         <= win_d;
                matrix_p      <= pad_p;
                matrix_border <= border_d;
            end
        end
    end

endmodule

// File: tb/tb_vip_matrix_window_5x5.sv
// Scoreboard bench for vip_matrix_window_5x5 using directed frames.
module tb_vip_matrix_window_5x5;

    localparam int DW = 8;

    typedef struct packed {
        logic [25*DW-1:0] p;
        logic             border;
    } exp_t;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic              per_frame_vsync = 1'b0;
    logic              per_frame_href = 1'b0;
    logic              per_frame_clken = 1'b0;
    logic [DW-1:0]     in_row0 = '0;
    logic [DW-1:0]     in_row1 = '0;
    logic [DW-1:0]     in_row2 = '0;
    logic [DW-1:0]     in_row3 = '0;
    logic [DW-1:0]     in_row4 = '0;
    logic              matrix_frame_vsync;
    logic              matrix_frame_href;
    logic              matrix_frame_clken;
    logic [25*DW-1:0]  matrix_p;
    logic              matrix_border;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    vip_matrix_window_5x5 dut (
        .clock              (clock),
        .rst_n              (rst_n),
        .per_frame_vsync    (per_frame_vsync),
        .per_frame_href     (per_frame_href),
        .per_frame_clken    (per_frame_clken),
        .in_row0            (in_row0),
        .in_row1            (in_row1),
        .in_row2            (in_row2),
        .in_row3            (in_row3),
        .in_row4            (in_row4),
        .matrix_frame_vsync (matrix_frame_vsync),
        .matrix_frame_href  (matrix_frame_href),
        .matrix_frame_clken (matrix_frame_clken),
        .matrix_p           (matrix_p),
        .matrix_border      (matrix_border)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [25*DW-1:0] act, input logic [25*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c, input logic [DW-1:0] base);
        return DW'(int'(base) + r * 16 + c);
    endfunction

    // Line-buffer tap k for pixel (r,c): rows above the frame carry junk.
    function automatic logic [DW-1:0] tap(input int r, input int k, input int c, input logic [DW-1:0] base);
        return (r - k >= 0) ? pix(r - k, c, base) : 8'hEE;
    endfunction

    function automatic exp_t model(input int row, input int col, input logic [DW-1:0] base);
        exp_t e;
        int   ri;
        int   ci;
        e.p      = '0;
        e.border = (row < 4) || (col < 4);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                ri = row - (4 - r);
                ci = col - (4 - c);
`ifdef VIP_MATRIX_BORDER_REPLICATE_EN
                if (ri < 0) ri = 0;
                if (ci < 0) ci = 0;
                e.p[(r*5+c)*DW +: DW] = pix(ri, ci, base);
`else
                e.p[(r*5+c)*DW +: DW] = (ri < 0 || ci < 0) ? 8'h00 : pix(ri, ci, base);
`endif
            end
        end
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #1;
        rst_n           = 1'b0;
        per_frame_clken = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
    endtask

    // One frame of w x h pixels, one clken every `gap` cycles; abort_row >= 0 resets mid-line.
    task automatic drive_frame(input int w, input int h, input int gap,
                               input logic [DW-1:0] base, input int abort_row);
        per_frame_vsync = 1'b1;
        idle(2);
        for (int r = 0; r < h; r++) begin
            per_frame_href = 1'b1;
            for (int c = 0; c < w; c++) begin
                if (r == abort_row && c == 2) begin
                    pulse_reset();
                    per_frame_vsync = 1'b0;
                    per_frame_href  = 1'b0;
                    idle(3);
                    return;
                end
                in_row0 = tap(r, 0, c, base);
                in_row1 = tap(r, 1, c, base);
                in_row2 = tap(r, 2, c, base);
                in_row3 = tap(r, 3, c, base);
                in_row4 = tap(r, 4, c, base);
                per_frame_clken = 1'b1;
                sb.push_back(model(r, c, base));
                idle(1);
                for (int g = 1; g < gap; g++) begin
                    per_frame_clken = 1'b0;
                    {in_row0, in_row1, in_row2, in_row3, in_row4} = {5{8'h33}};
                    idle(1);
                end
            end
            per_frame_clken = 1'b0;
            per_frame_href  = 1'b0;
            idle(3);
        end
        per_frame_vsync = 1'b0;
        idle(3);
    endtask

    // Monitor: sync delay, scoreboard pops on valid, window hold between strobes.
    initial begin : monitor
        exp_t       e;
        logic [199:0] hold_p;
        logic       hold_b;
        logic       prev_vs;
        logic       prev_hr;
        logic       prev_ck;
        hold_p  = '0;
        hold_b  = 1'b0;
        prev_vs = 1'b0;
        prev_hr = 1'b0;
        prev_ck = 1'b0;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                check("reset_p", matrix_p, '0);
                check("reset_border", 200'(matrix_border), '0);
                check("reset_sync", 200'({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken}), '0);
                hold_p  = '0;
                hold_b  = 1'b0;
                prev_vs = 1'b0;
                prev_hr = 1'b0;
                prev_ck = 1'b0;
            end else begin
                check("vsync_dly", 200'(matrix_frame_vsync), 200'(prev_vs));
                check("href_dly", 200'(matrix_frame_href), 200'(prev_hr));
                check("clken_dly", 200'(matrix_frame_clken), 200'(prev_ck));
                if (matrix_frame_clken) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 200'(1), 200'(0));
                    end else begin
                        e = sb.pop_front();
                        check("window", matrix_p, e.p);
                        check("border", 200'(matrix_border), 200'(e.border));
                        hold_p = e.p;
                        hold_b = e.border;
                    end
                end else begin
                    check("hold_p", matrix_p, hold_p);
                    check("hold_border", 200'(matrix_border), 200'(hold_b));
                end
                prev_vs = per_frame_vsync;
                prev_hr = per_frame_href;
                prev_ck = per_frame_clken;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        idle(3);
        rst_n = 1'b1;
        {in_row0, in_row1, in_row2, in_row3, in_row4} = {5{8'hAA}};
        idle(10);
        drive_frame(8, 6, 1, 8'h00, -1);
        drive_frame(6, 5, 3, 8'h00, -1);
        drive_frame(8, 6, 1, 8'h00, 3);
        drive_frame(8, 6, 1, 8'h00, -1);
        drive_frame(5, 5, 1, 8'h5A, -1);
        idle(4);
        check("sb_drain", 200'(sb.size()), 200'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
